// File: rtl/mempool_resp_age_rr_arbiter.sv
// rtl/mempool_resp_age_rr_arbiter.sv - oldest-first N-to-1 response arbiter with round-robin tie break
// One-entry output register; per-input saturating wait ages drive priority and starvation flags.
module mempool_resp_age_rr_arbiter #(
    parameter int unsigned NumInp       = 8,
    parameter int unsigned AgeWidth     = 4,
    parameter int unsigned StarveThresh = 12,
    parameter type         payload_t    = logic,
    localparam int unsigned IdxWidth    = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  payload_t                data_i [NumInp],
    input  logic [NumInp-1:0]       valid_i,
    output logic [NumInp-1:0]       ready_o,
    output payload_t                data_o,
    output logic [IdxWidth-1:0]     idx_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [NumInp-1:0]       starve_o
);

    localparam logic [IdxWidth:0]   NumInpW  = (IdxWidth+1)'(NumInp);
    localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(NumInp - 1);
    localparam logic [AgeWidth-1:0] ThreshW  = AgeWidth'(StarveThresh);

    logic [AgeWidth-1:0] r_age [NumInp];
    logic [IdxWidth-1:0] r_rr;
    logic                r_valid;
    payload_t            r_data;
    logic [IdxWidth-1:0] r_idx;

    logic [AgeWidth-1:0] w_maxage;
    logic                w_found;
    logic [IdxWidth-1:0] w_win;
    logic [IdxWidth:0]   w_sum;
    logic [IdxWidth-1:0] w_pos;
    logic                w_can_load;
    logic                w_grant;
    logic [IdxWidth-1:0] w_rr_nxt;

    assign w_can_load = ~r_valid | ready_i;
    assign w_grant    = w_found & w_can_load & ~rst_i;
    assign w_rr_nxt   = (w_win == LastIdx) ? '0 : w_win + 1'b1;

    always_comb begin
        w_maxage = '0;
        for (int i = 0; i < NumInp; i++) begin
            if (valid_i[i] && (r_age[i] > w_maxage)) begin
                w_maxage = r_age[i];
            end
        end
    end

    // Cyclic scan starting at r_rr: the first oldest candidate wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_pos   = '0;
        for (int k = 0; k < NumInp; k++) begin
            w_sum = {1'b0, r_rr} + (IdxWidth+1)'(k);
            if (w_sum >= NumInpW) begin
                w_sum = w_sum - NumInpW;
            end
            w_pos = w_sum[IdxWidth-1:0];
            if (!w_found && valid_i[w_pos] && (r_age[w_pos] == w_maxage)) begin
                w_found = 1'b1;
                w_win   = w_pos;
            end
        end
    end

    always_comb begin
        ready_o = '0;
        if (w_grant) begin
            ready_o[w_win] = 1'b1;
        end
    end

    always_comb begin
        starve_o = '0;
        for (int i = 0; i < NumInp; i++) begin
            starve_o[i] = (r_age[i] >= ThreshW);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_rr    <= '0;
        end else if (w_grant) begin
            r_valid <= 1'b1;
            r_data  <= data_i[w_win];
            r_idx   <= w_win;
            r_rr    <= w_rr_nxt;
        end else if (ready_i) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NumInp; i++) begin
            if (rst_i || !valid_i[i] || ready_o[i]) begin
                r_age[i] <= '0;
            end else if (r_age[i] != {AgeWidth{1'b1}}) begin
                r_age[i] <= r_age[i] + 1'b1;
            end
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign idx_o   = r_idx;

    a_ready_onehot0: assert property (@(posedge clk_i) $onehot0(ready_o));
    a_hold_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i) |=> ($stable(data_o) && $stable(idx_o)));
    a_thresh_range: assert property (@(posedge clk_i) StarveThresh < (2 ** AgeWidth));

endmodule

// File: tb/tb_mempool_resp_age_rr_arbiter.sv
// tb/tb_mempool_resp_age_rr_arbiter.sv - directed and random checks against a behavioural arbiter model
module tb_mempool_resp_age_rr_arbiter;

    localparam int N = 8;
    localparam int AMAX = 15;
    localparam int THR = 12;

    logic             clk;
    logic             cur_rst;
    logic [7:0]       d_in [N];
    logic [N-1:0]     cur_v;
    logic [N-1:0]     ready_o;
    logic [7:0]       data_o;
    logic [2:0]       idx_o;
    logic             valid_o;
    logic             cur_rdy;
    logic [N-1:0]     starve_o;

    int n_checks = 0;
    int n_fail   = 0;

    int         m_age [N];
    int         m_rr;
    bit         m_vo;
    logic [7:0] m_do;
    int         m_io;
    int         last_gnt;

    mempool_resp_age_rr_arbiter #(
        .NumInp(N), .AgeWidth(4), .StarveThresh(THR), .payload_t(logic [7:0])
    ) dut (
        .clk_i(clk), .rst_i(cur_rst), .data_i(d_in), .valid_i(cur_v), .ready_o(ready_o),
        .data_o(data_o), .idx_o(idx_o), .valid_o(valid_o), .ready_i(cur_rdy), .starve_o(starve_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_age[i] = 0;
        m_rr = 0; m_vo = 0; m_do = 8'h00; m_io = 0;
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        int maxa;
        int win;
        int p;
        bit cl;
        logic [7:0] er;
        logic [7:0] es;
        #1;
        win = -1;
        if (!cur_rst) begin
            cl = !m_vo || cur_rdy;
            maxa = -1;
            for (int i = 0; i < N; i++) if (cur_v[i] && m_age[i] > maxa) maxa = m_age[i];
            if (cl && maxa >= 0) begin
                for (int k = 0; k < N; k++) begin
                    p = (m_rr + k) % N;
                    if (win < 0 && cur_v[p] && m_age[p] == maxa) win = p;
                end
            end
        end
        er = (win >= 0) ? 8'(1 << win) : 8'h00;
        for (int i = 0; i < N; i++) es[i] = (m_age[i] >= THR);
        chk("ready_o", ready_o, er);
        chk("starve_o", starve_o, es);
        chk("valid_o", valid_o, m_vo);
        chk("data_o", data_o, m_do);
        chk("idx_o", idx_o, m_io);
        last_gnt = win;
        if (cur_rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!cur_v[i] || i == win) m_age[i] = 0;
                else if (m_age[i] < AMAX) m_age[i] = m_age[i] + 1;
            end
            if (win >= 0) begin
                m_vo = 1; m_do = d_in[win]; m_io = win; m_rr = (win + 1) % N;
            end else if (cur_rdy) begin
                m_vo = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        cur_rst = 1'b1; cur_v = '0; cur_rdy = 1'b0;
        for (int c = 0; c < cycles; c++) step();
        cur_rst = 1'b0;
    endtask

    initial begin
        cur_rst = 1'b1; cur_v = '0; cur_rdy = 1'b0;
        for (int i = 0; i < N; i++) d_in[i] = 8'h00;
        @(negedge clk);
        @(negedge clk);
        model_reset();

        // Reset and idle
        do_reset(2);
        cur_rdy = 1'b1;
        for (int c = 0; c < 3; c++) step();

        // Round-robin on ties
        do_reset(1);
        for (int i = 0; i < N; i++) d_in[i] = 8'(8'h30 + i);
        cur_v = '1; cur_rdy = 1'b1;
        for (int c = 0; c < 9; c++) begin
            step();
            chk("rr_idx", idx_o, c % N);
            chk("rr_valid", valid_o, 1);
        end

        // Age priority: 5 first, then 2 and 3 tie after backpressure
        do_reset(1);
        cur_v = 8'h20; d_in[5] = 8'h55; cur_rdy = 1'b0;
        step();
        chk("age_first", idx_o, 5);
        cur_v = 8'h0C; d_in[2] = 8'h22; d_in[3] = 8'h33;
        step();
        step();
        cur_rdy = 1'b1;
        #1 chk("age_tie_ready", ready_o, 8'h04);
        step();
        chk("age_second", idx_o, 2);
        cur_v = 8'h08;
        step();
        chk("age_third", idx_o, 3);

        // Saturation and starvation on input 0
        do_reset(1);
        cur_v = 8'h02; d_in[1] = 8'h11; cur_rdy = 1'b0;
        step();
        cur_v = 8'h01; d_in[0] = 8'h01;
        for (int n = 0; n < 22; n++) begin
            step();
            chk("starve_sat", starve_o[0], ((n + 1) >= THR) ? 1 : 0);
        end
        cur_rdy = 1'b1;
        step();
        chk("starve_drain", idx_o, 0);

        // Backpressure hold
        do_reset(1);
        cur_v = 8'h10; d_in[4] = 8'hA5; cur_rdy = 1'b0;
        step();
        cur_v = 8'h06; d_in[1] = 8'h9A; d_in[2] = 8'h9B;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_ready", ready_o, 8'h00);
            chk("bp_data", data_o, 8'hA5);
            chk("bp_idx", idx_o, 4);
            chk("bp_valid", valid_o, 1);
            step();
        end
        cur_rdy = 1'b1;
        #1 chk("bp_release", ready_o, 8'h02);
        step();

        // Withdraw clears age, then reset while holding
        do_reset(1);
        cur_v = 8'h01; d_in[0] = 8'h0F; cur_rdy = 1'b0;
        step();
        cur_v = 8'h40; d_in[6] = 8'h66;
        for (int c = 0; c < 3; c++) step();
        cur_v = 8'h00;
        step();
        cur_v = 8'h80; d_in[7] = 8'h77;
        step();
        cur_v = 8'hC0; cur_rdy = 1'b1;
        #1 chk("withdraw_age", ready_o, 8'h80);
        step();
        cur_v = 8'h02; d_in[1] = 8'h12; cur_rdy = 1'b0;
        step();
        cur_rst = 1'b1;
        #1 chk("rst_ready", ready_o, 8'h00);
        step();
        chk("rst_drop", valid_o, 0);
        step();
        cur_rst = 1'b0;

        // Randomized traffic
        cur_v = '0;
        for (int c = 0; c < 800; c++) begin
            cur_rst = ($urandom_range(0, 199) == 0);
            cur_rdy = ($urandom_range(0, 3) != 0);
            step();
            if (cur_rst) cur_v = '0;
            else if (last_gnt >= 0) cur_v[last_gnt] = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (!cur_v[i] && $urandom_range(0, 2) == 0) begin
                    cur_v[i] = 1'b1;
                    d_in[i]  = 8'($urandom);
                end else if (cur_v[i] && $urandom_range(0, 39) == 0) begin
                    cur_v[i] = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
